// File: rtl/midi_note_rx_if.sv
// Output bundle of the MIDI receiver.
//   rx_byte       last good byte, held until the next good frame
//   rx_byte_valid one-cycle pulse per good frame
//   framing_err   one-cycle pulse when a stop bit samples low
//   note          current note number
//   velocity      velocity of the current note
//   gate          high while the current note is held
//   note_valid    one-cycle pulse when a note-on updates note/velocity/gate
// master: driven by midi_note_rx; slave: consumer side.
interface midi_note_rx_if;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       framing_err;
  logic [6:0] note;
  logic [6:0] velocity;
  logic       gate;
  logic       note_valid;

  modport master (
    output rx_byte, rx_byte_valid, framing_err, note, velocity, gate, note_valid
  );

  modport slave (
    input rx_byte, rx_byte_valid, framing_err, note, velocity, gate, note_valid
  );
endinterface

// File: rtl/midi_note_rx.sv
// Serial MIDI receiver (8N1 UART) with a channel-voice parser that tracks the
// sounding note, its velocity and a gate.
//   clk_i   system clock
//   rst_i   synchronous reset, active-high
//   rx_i    asynchronous serial line, idle high
//   out_if  byte stream, framing error and note/velocity/gate outputs
module midi_note_rx #(
  parameter int unsigned CLKSPEED = 48_000_000,
  parameter int unsigned BAUD     = 31_250,
  parameter int unsigned CHANNEL  = 0,
  parameter bit          OMNI     = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           rx_i,
  midi_note_rx_if.master out_if
);

  localparam int unsigned ClksPerBit = CLKSPEED / BAUD;
  localparam int unsigned HalfBit    = ClksPerBit / 2;
  localparam int unsigned CntW       = $clog2(ClksPerBit + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} uart_state_e;

  // Synchronizer resets high so a reset never looks like a start bit.
  logic rx_meta_q, rx_sync_q;

  uart_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            bv_q, bv_d;
  logic            fe_q, fe_d;

  // Parser state; status_q[7] = 0 means no running status.
  logic [7:0] status_q, status_d;
  logic       dcnt_q, dcnt_d;
  logic [6:0] d1_q, d1_d;
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic       gate_q, gate_d;
  logic       nv_q, nv_d;

  logic       need_two, chan_ok;
  logic [6:0] msg_d1, msg_d2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      bv_q      <= 1'b0;
      fe_q      <= 1'b0;
      status_q  <= '0;
      dcnt_q    <= 1'b0;
      d1_q      <= '0;
      note_q    <= '0;
      vel_q     <= '0;
      gate_q    <= 1'b0;
      nv_q      <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      bv_q      <= bv_d;
      fe_q      <= fe_d;
      status_q  <= status_d;
      dcnt_q    <= dcnt_d;
      d1_q      <= d1_d;
      note_q    <= note_d;
      vel_q     <= vel_d;
      gate_q    <= gate_d;
      nv_q      <= nv_d;
    end
  end

  // UART receive FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_sync_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            byte_d  = shift_q;
            bv_d    = 1'b1;
            state_d = StIdle;
          end else begin
            fe_d    = 1'b1;
            state_d = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitHigh: begin
        if (rx_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Program change and channel pressure carry a single data byte.
  assign need_two = (status_q[7:4] != 4'hC) && (status_q[7:4] != 4'hD);
  assign chan_ok  = OMNI || (status_q[3:0] == 4'(CHANNEL));

  // Message parser, advanced once per received byte
  always_comb begin
    status_d = status_q;
    dcnt_d   = dcnt_q;
    d1_d     = d1_q;
    note_d   = note_q;
    vel_d    = vel_q;
    gate_d   = gate_q;
    nv_d     = 1'b0;
    msg_d1   = need_two ? d1_q : byte_q[6:0];
    msg_d2   = byte_q[6:0];
    if (bv_q) begin
      if (byte_q >= 8'hF8) begin
        // realtime: transparent to running status
      end else if (byte_q[7:4] == 4'hF) begin
        status_d = '0;
        dcnt_d   = 1'b0;
      end else if (byte_q[7]) begin
        status_d = byte_q;
        dcnt_d   = 1'b0;
      end else if (status_q[7]) begin
        if (need_two && !dcnt_q) begin
          d1_d   = byte_q[6:0];
          dcnt_d = 1'b1;
        end else begin
          dcnt_d = 1'b0;
          if (chan_ok) begin
            if (status_q[7:4] == 4'h9 && msg_d2 != 7'd0) begin
              note_d = msg_d1;
              vel_d  = msg_d2;
              gate_d = 1'b1;
              nv_d   = 1'b1;
            end else if ((status_q[7:4] == 4'h8 || status_q[7:4] == 4'h9) &&
                         msg_d1 == note_q) begin
              gate_d = 1'b0;
            end
          end
        end
      end
    end
  end

  assign out_if.rx_byte       = byte_q;
  assign out_if.rx_byte_valid = bv_q;
  assign out_if.framing_err   = fe_q;
  assign out_if.note          = note_q;
  assign out_if.velocity      = vel_q;
  assign out_if.gate          = gate_q;
  assign out_if.note_valid    = nv_q;

endmodule

// File: tb/tb_midi_note_rx.sv
module tb_midi_note_rx;
  localparam int Cpb = 16;  // 500 kHz clock, 31250 baud

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  midi_note_rx_if if0 ();
  midi_note_rx_if if1 ();

  midi_note_rx #(.CLKSPEED(500_000), .BAUD(31_250), .CHANNEL(0), .OMNI(1'b0)) dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .rx_i  (rx),
    .out_if(if0)
  );

  midi_note_rx #(.CLKSPEED(500_000), .BAUD(31_250), .CHANNEL(0), .OMNI(1'b1)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .rx_i  (rx),
    .out_if(if1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse counters
  int bv_cnt[2];
  int nv_cnt[2];
  int fe_cnt[2];
  initial begin
    for (int i = 0; i < 2; i++) begin
      bv_cnt[i] = 0;
      nv_cnt[i] = 0;
      fe_cnt[i] = 0;
    end
  end
  always @(negedge clk) begin
    if (if0.rx_byte_valid) bv_cnt[0]++;
    if (if1.rx_byte_valid) bv_cnt[1]++;
    if (if0.note_valid)    nv_cnt[0]++;
    if (if1.note_valid)    nv_cnt[1]++;
    if (if0.framing_err)   fe_cnt[0]++;
    if (if1.framing_err)   fe_cnt[1]++;
  end

  // Reference model: MIDI running-status semantics per instance
  int m_rs[2];
  int m_n[2];
  int m_buf[2][2];
  int m_note[2];
  int m_vel[2];
  int m_gate[2];
  int m_omni[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rs[i]   = -1;
      m_n[i]    = 0;
      m_note[i] = 0;
      m_vel[i]  = 0;
      m_gate[i] = 0;
    end
    m_omni[0] = 0;
    m_omni[1] = 1;
  endtask

  task automatic model_byte(input int i, input int b, output int nv);
    int need;
    int kind;
    nv = 0;
    if (b >= 'hF8) return;
    if (b >= 'hF0) begin
      m_rs[i] = -1;
      m_n[i]  = 0;
      return;
    end
    if (b >= 'h80) begin
      m_rs[i] = b;
      m_n[i]  = 0;
      return;
    end
    if (m_rs[i] < 0) return;
    kind = m_rs[i] / 16;
    need = (kind == 12 || kind == 13) ? 1 : 2;
    m_buf[i][m_n[i]] = b;
    m_n[i]++;
    if (m_n[i] < need) return;
    m_n[i] = 0;
    if (!(m_omni[i] != 0 || (m_rs[i] % 16) == 0)) return;
    if (kind == 9 && m_buf[i][1] != 0) begin
      m_note[i] = m_buf[i][0];
      m_vel[i]  = m_buf[i][1];
      m_gate[i] = 1;
      nv = 1;
    end else if ((kind == 8 || kind == 9) && m_buf[i][0] == m_note[i]) begin
      m_gate[i] = 0;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_clks(Cpb);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      wait_clks(Cpb);
    end
    rx = stop;
    wait_clks(Cpb);
  endtask

  // Sends one good frame and checks both instances against the model.
  task automatic send_byte(input int b, input string tag);
    int bv0, bv1, nvb0, nvb1, nv0, nv1;
    bv0  = bv_cnt[0];
    bv1  = bv_cnt[1];
    nvb0 = nv_cnt[0];
    nvb1 = nv_cnt[1];
    send_frame(8'(b), 1'b1);
    rx = 1'b1;
    wait_clks(4);
    model_byte(0, b, nv0);
    model_byte(1, b, nv1);
    check({tag, " rx_byte0"}, int'(if0.rx_byte), b);
    check({tag, " rx_byte1"}, int'(if1.rx_byte), b);
    check({tag, " bv_pulses0"}, bv_cnt[0] - bv0, 1);
    check({tag, " bv_pulses1"}, bv_cnt[1] - bv1, 1);
    check({tag, " nv_pulses0"}, nv_cnt[0] - nvb0, nv0);
    check({tag, " nv_pulses1"}, nv_cnt[1] - nvb1, nv1);
    check({tag, " note0"}, int'(if0.note), m_note[0]);
    check({tag, " note1"}, int'(if1.note), m_note[1]);
    check({tag, " vel0"}, int'(if0.velocity), m_vel[0]);
    check({tag, " vel1"}, int'(if1.velocity), m_vel[1]);
    check({tag, " gate0"}, int'(if0.gate), m_gate[0]);
    check({tag, " gate1"}, int'(if1.gate), m_gate[1]);
  endtask

  typedef struct {
    int b;
    int n0, v0, g0;
    int n1, g1;
  } vec_t;

  vec_t tab[$];

  task automatic add(input int b, input int n0, input int v0, input int g0, input int n1,
                     input int g1);
    vec_t v;
    v.b  = b;
    v.n0 = n0;
    v.v0 = v0;
    v.g0 = g0;
    v.n1 = n1;
    v.g1 = g1;
    tab.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int fe0, fe1, bv0, bv1;
    int r, b;

    // Note-on, running status, realtime mid-message
    add('h90, 0, 0, 0, 0, 0);       add('h3C, 0, 0, 0, 0, 0);
    add('h64, 60, 100, 1, 60, 1);
    add('h3E, 60, 100, 1, 60, 1);   add('h40, 62, 64, 1, 62, 1);
    add('h3E, 62, 64, 1, 62, 1);    add('h00, 62, 64, 0, 62, 0);
    add('h90, 62, 64, 0, 62, 0);    add('h3C, 62, 64, 0, 62, 0);
    add('hF8, 62, 64, 0, 62, 0);    add('h50, 60, 80, 1, 60, 1);
    // Channel 1: only the omni instance reacts
    add('h91, 60, 80, 1, 60, 1);    add('h40, 60, 80, 1, 60, 1);
    add('h40, 60, 80, 1, 64, 1);
    // Note-off of a different note, then of the held note
    add('h80, 60, 80, 1, 64, 1);    add('h41, 60, 80, 1, 64, 1);
    add('h00, 60, 80, 1, 64, 1);
    add('h80, 60, 80, 1, 64, 1);    add('h3C, 60, 80, 1, 64, 1);
    add('h00, 60, 80, 0, 64, 1);
    // One-data-byte message, then sysex clears running status
    add('hC0, 60, 80, 0, 64, 1);    add('h05, 60, 80, 0, 64, 1);
    add('hF0, 60, 80, 0, 64, 1);    add('h3C, 60, 80, 0, 64, 1);
    add('h64, 60, 80, 0, 64, 1);
    add('h90, 60, 80, 0, 64, 1);    add('h3C, 60, 80, 0, 64, 1);
    add('h64, 60, 100, 1, 60, 1);

    model_reset();
    wait_clks(4);
    check("reset note0", int'(if0.note), 0);
    check("reset vel0", int'(if0.velocity), 0);
    check("reset gate0", int'(if0.gate), 0);
    check("reset rx_byte0", int'(if0.rx_byte), 0);
    check("reset bv0", int'(if0.rx_byte_valid), 0);
    check("reset gate1", int'(if1.gate), 0);
    rst = 1'b0;
    wait_clks(2 * Cpb);

    for (int i = 0; i < tab.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      send_byte(tab[i].b, tag);
      check({tag, " tab note0"}, int'(if0.note), tab[i].n0);
      check({tag, " tab vel0"}, int'(if0.velocity), tab[i].v0);
      check({tag, " tab gate0"}, int'(if0.gate), tab[i].g0);
      check({tag, " tab note1"}, int'(if1.note), tab[i].n1);
      check({tag, " tab gate1"}, int'(if1.gate), tab[i].g1);
      wait_clks($urandom_range(0, 5));
    end

    // Start-bit glitch: no byte, no framing error
    bv0 = bv_cnt[0];
    fe0 = fe_cnt[0];
    rx = 1'b0;
    wait_clks(3);
    rx = 1'b1;
    wait_clks(2 * Cpb);
    check("glitch bv", bv_cnt[0] - bv0, 0);
    check("glitch fe", fe_cnt[0] - fe0, 0);

    // Bad stop bit, line held low for 3 more bit times, then recovery
    bv0 = bv_cnt[0];
    bv1 = bv_cnt[1];
    fe0 = fe_cnt[0];
    fe1 = fe_cnt[1];
    send_frame(8'h55, 1'b0);
    wait_clks(3 * Cpb);
    rx = 1'b1;
    wait_clks(Cpb);
    check("ferr fe0", fe_cnt[0] - fe0, 1);
    check("ferr fe1", fe_cnt[1] - fe1, 1);
    check("ferr bv0", bv_cnt[0] - bv0, 0);
    check("ferr bv1", bv_cnt[1] - bv1, 0);
    send_byte('h80, "rec0");
    send_byte('h3C, "rec1");
    send_byte('h00, "rec2");
    check("recover gate0", int'(if0.gate), 0);
    check("recover note0", int'(if0.note), 60);

    // Reset in the middle of the second byte's data bits
    send_byte('h90, "rst0");
    rx = 1'b0;
    wait_clks(Cpb);
    for (int k = 0; k < 4; k++) begin
      rx = (k >= 2) ? 1'b1 : 1'b0;  // low nibble of 0x3C
      wait_clks(Cpb);
    end
    rst = 1'b1;
    rx  = 1'b1;
    wait_clks(2);
    check("midrst note0", int'(if0.note), 0);
    check("midrst vel0", int'(if0.velocity), 0);
    check("midrst gate0", int'(if0.gate), 0);
    check("midrst rx_byte0", int'(if0.rx_byte), 0);
    check("midrst note1", int'(if1.note), 0);
    model_reset();
    rst = 1'b0;
    wait_clks(2 * Cpb);
    send_byte('h90, "post0");
    send_byte('h3C, "post1");
    send_byte('h64, "post2");
    check("post note0", int'(if0.note), 60);
    check("post gate0", int'(if0.gate), 1);

    // Randomized byte stream against the model
    send_byte('h90, "rnd_init");
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 14) begin
        case ($urandom_range(0, 3))
          0: b = 'h80;
          1: b = 'h90;
          2: b = 'hC0;
          default: b = 'hB0;
        endcase
        b = b + int'($urandom_range(0, 1));
      end else if (r < 19) begin
        b = 'hF8 + int'($urandom_range(0, 7));
      end else if (r < 22) begin
        b = 'hF0 + int'($urandom_range(0, 7));
      end else if (r < 40) begin
        b = 0;
      end else if (r < 75) begin
        b = int'($urandom_range('h3C, 'h3F));
      end else begin
        b = int'($urandom_range(0, 127));
      end
      send_byte(b, $sformatf("rnd%0d", i));
      wait_clks($urandom_range(0, 20));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
